// File: rtl/psp_icache.sv
// psp_icache: direct-mapped, read-only instruction cache sitting between the
// core fetch port and main-memory port A. Misses refill a whole line with a
// back-to-back burst of single-word reads; memory is never written.
module psp_icache #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic [ADDR_W-1:0] core_req_addr,
  output logic              core_resp_valid,
  output logic [DATA_W-1:0] core_resp_data,
  input  logic              flush,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] mem_data_o,
  output logic              mem_data_en,
  output logic              mem_write_en
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - OW - IW;

  localparam logic [OW:0]   CNT_ONE     = (OW+1)'(1);
  localparam logic [OW:0]   CNT_LAST_RD = (OW+1)'(LINE_WORDS - 1);
  localparam logic [OW:0]   CNT_DONE    = (OW+1)'(LINE_WORDS);
  localparam logic [OW-1:0] OFF_ONE     = OW'(1);
  localparam logic [OW-1:0] OFF_LAST    = OW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, HIT, FILL, RESP} state_t;

  state_t            state;
  logic [LINES-1:0]  valid;
  logic [TW-1:0]     tags  [LINES];
  logic [DATA_W-1:0] lines [LINES*LINE_WORDS];
  logic              flush_pend;
  logic [OW:0]       cnt;
  logic [ADDR_W-1:0] req_addr;

  logic [OW-1:0] in_off;
  logic [IW-1:0] in_idx;
  logic [TW-1:0] in_tag;
  logic [OW-1:0] r_off;
  logic [IW-1:0] r_idx;
  logic [TW-1:0] r_tag;
  logic [OW-1:0] fill_off;
  logic          hit;

  assign in_off = core_req_addr[OW-1:0];
  assign in_idx = core_req_addr[OW+IW-1:OW];
  assign in_tag = core_req_addr[ADDR_W-1:OW+IW];

  assign r_off = req_addr[OW-1:0];
  assign r_idx = req_addr[OW+IW-1:OW];
  assign r_tag = req_addr[ADDR_W-1:OW+IW];

  // Word captured this cycle lags the counter by one because memory is synchronous
  assign fill_off = cnt[OW-1:0] - OFF_ONE;

  assign hit = valid[in_idx] && (tags[in_idx] == in_tag);

  assign core_req_ready = rst_n && (state == IDLE) && !flush && !flush_pend;

  assign mem_data_i   = '0;
  assign mem_write_en = 1'b0;

  // Control FSM: accept, hit/fill sequencing, flush handling and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      valid           <= '0;
      flush_pend      <= 1'b0;
      cnt             <= '0;
      req_addr        <= '0;
      core_resp_valid <= 1'b0;
      core_resp_data  <= '0;
      mem_data_en     <= 1'b0;
      mem_addr        <= '0;
    end else begin
      core_resp_valid <= 1'b0;
      if (flush && state != IDLE) flush_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (flush || flush_pend) begin
            valid      <= '0;
            flush_pend <= 1'b0;
          end else if (core_req_valid) begin
            req_addr <= core_req_addr;
            if (hit) begin
              state           <= HIT;
              core_resp_valid <= 1'b1;
              core_resp_data  <= lines[{in_idx, in_off}];
            end else begin
              state       <= FILL;
              cnt         <= '0;
              mem_data_en <= 1'b1;
              mem_addr    <= {in_tag, in_idx, {OW{1'b0}}};
            end
          end
        end
        HIT: begin
          state <= IDLE;
        end
        FILL: begin
          cnt <= cnt + CNT_ONE;
          if (cnt == CNT_LAST_RD) mem_data_en <= 1'b0;
          else if (cnt < CNT_LAST_RD) mem_addr[OW-1:0] <= mem_addr[OW-1:0] + OFF_ONE;
          if (cnt == CNT_DONE) begin
            valid[r_idx]    <= 1'b1;
            state           <= RESP;
            cnt             <= '0;
            core_resp_valid <= 1'b1;
            core_resp_data  <= (r_off == OFF_LAST) ? mem_data_o : lines[{r_idx, r_off}];
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data and tag storage; validity lives in the reset block so these need no reset
  always_ff @(posedge clk) begin
    if (state == FILL && cnt != '0) lines[{r_idx, fill_off}] <= mem_data_o;
    if (state == FILL && cnt == CNT_DONE) tags[r_idx] <= r_tag;
  end

endmodule
